// File: rtl/sign_phase_sequencer_if.sv
// Handshake and data bundle between the signature sequencer and its sub-engines.
interface sign_phase_sequencer_if #(
    parameter int RIDX_W = 10,
    parameter int CH_W   = 512,
    parameter int CV_W   = 512,
    parameter int MK_W   = 255,
    parameter int LC_W   = 680,
    parameter int LP_W   = 340
);
    logic              sign_start;
    logic              sign_abort;
    logic              sign_busy;
    logic              sign_end;
    logic              sign_err;
    logic              tree_start;
    logic              tree_done;
    logic              rnd_start;
    logic              rnd_done;
    logic [RIDX_W-1:0] rnd_idx;
    logic [CH_W-1:0]   rnd_ch;
    logic [CV_W-1:0]   rnd_cv;
    logic [MK_W-1:0]   rnd_mk;
    logic              wr_en;
    logic [RIDX_W-1:0] wr_addr;
    logic [CH_W-1:0]   wr_ch;
    logic [CV_W-1:0]   wr_cv;
    logic [MK_W-1:0]   wr_mk;
    logic              mt_start;
    logic              mt_done;
    logic [CV_W-1:0]   mt_root;
    logic              hcp_start;
    logic              hcp_done;
    logic [LC_W-1:0]   hcp_lc;
    logic [LP_W-1:0]   hcp_lp;
    logic [CV_W-1:0]   cv_root;
    logic [LC_W-1:0]   lc;
    logic [LP_W-1:0]   lp;

    modport master (
        input  sign_start, sign_abort,
        output sign_busy, sign_end, sign_err,
        output tree_start, input tree_done,
        output rnd_start, input rnd_done, output rnd_idx,
        input  rnd_ch, rnd_cv, rnd_mk,
        output wr_en, wr_addr, wr_ch, wr_cv, wr_mk,
        output mt_start, input mt_done, mt_root,
        output hcp_start, input hcp_done, hcp_lc, hcp_lp,
        output cv_root, lc, lp
    );

    modport slave (
        output sign_start, sign_abort,
        input  sign_busy, sign_end, sign_err,
        input  tree_start, output tree_done,
        input  rnd_start, output rnd_done, input rnd_idx,
        output rnd_ch, rnd_cv, rnd_mk,
        input  wr_en, wr_addr, wr_ch, wr_cv, wr_mk,
        input  mt_start, output mt_done, mt_root,
        input  hcp_start, output hcp_done, hcp_lc, hcp_lp,
        input  cv_root, lc, lp
    );
endinterface

// File: rtl/sign_phase_sequencer.sv
// Signature phase sequencer: seed tree, T round commits, Merkle root, HCP challenge.
// Optional per-phase watchdog enabled by defining SIGN_WATCHDOG_EN.
module sign_phase_sequencer #(
    parameter int T_ROUNDS  = 601,
    parameter int RIDX_W    = 10,
    parameter int CH_W      = 512,
    parameter int CV_W      = 512,
    parameter int MK_W      = 255,
    parameter int LC_W      = 680,
    parameter int LP_W      = 340,
    parameter int TO_CYCLES = 65535
) (
    input logic                    clk,
    input logic                    reset,
    sign_phase_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_TREE, S_ROUND, S_ROUND_WR,
        S_MERKLE, S_HCP, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [RIDX_W-1:0] idx_q, idx_d;
    logic [RIDX_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CV_W-1:0]   cv_q, cv_d;
    logic [MK_W-1:0]   mk_q, mk_d;
    logic [CV_W-1:0]   root_q, root_d;
    logic [LC_W-1:0]   lc_q, lc_d;
    logic [LP_W-1:0]   lp_q, lp_d;
    logic              last_rnd;

    assign last_rnd = (idx_q == RIDX_W'(T_ROUNDS - 1));

`ifdef SIGN_WATCHDOG_EN
    localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timed, pdone, expired;

    always_comb begin
        timed = 1'b0;
        pdone = 1'b0;
        unique case (state_q)
            S_TREE:   begin timed = 1'b1; pdone = bus.tree_done; end
            S_ROUND:  begin timed = 1'b1; pdone = bus.rnd_done;  end
            S_MERKLE: begin timed = 1'b1; pdone = bus.mt_done;   end
            S_HCP:    begin timed = 1'b1; pdone = bus.hcp_done;  end
            default:  ;
        endcase
    end

    assign expired = timed && !pdone &&
                     (cnt_q == CNT_W'(TO_CYCLES - 1));

    // Counter restarts on every state entry, including ROUND re-entry.
    always_comb begin
        cnt_d = '0;
        if (timed && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        ch_d    = ch_q;
        cv_d    = cv_q;
        mk_d    = mk_q;
        root_d  = root_q;
        lc_d    = lc_q;
        lp_d    = lp_q;
`ifdef SIGN_WATCHDOG_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE:
                if (bus.sign_start) state_d = S_TREE;
            S_TREE:
                if (bus.tree_done) begin
                    idx_d   = '0;
                    state_d = S_ROUND;
                end
            S_ROUND:
                if (bus.rnd_done) begin
                    ch_d    = bus.rnd_ch;
                    cv_d    = bus.rnd_cv;
                    mk_d    = bus.rnd_mk;
                    addr_d  = idx_q;
                    wr_en_d = 1'b1;
                    state_d = S_ROUND_WR;
                end
            S_ROUND_WR:
                if (last_rnd) begin
                    state_d = S_MERKLE;
                end else begin
                    idx_d   = idx_q + RIDX_W'(1);
                    state_d = S_ROUND;
                end
            S_MERKLE:
                if (bus.mt_done) begin
                    root_d  = bus.mt_root;
                    state_d = S_HCP;
                end
            S_HCP:
                if (bus.hcp_done) begin
                    lc_d    = bus.hcp_lc;
                    lp_d    = bus.hcp_lp;
                    state_d = S_DONE;
                end
            S_DONE:
                if (!bus.sign_start) begin
                    state_d = S_IDLE;
`ifdef SIGN_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            default:
                state_d = S_IDLE;
        endcase
`ifdef SIGN_WATCHDOG_EN
        if (expired) begin
            state_d = S_DONE;
            err_d   = 1'b1;
        end
`endif
        // Abort beats any done arriving in the same cycle.
        if (bus.sign_abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            wr_en_d = 1'b0;
            root_d  = root_q;
            lc_d    = lc_q;
            lp_d    = lp_q;
`ifdef SIGN_WATCHDOG_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            ch_q    <= '0;
            cv_q    <= '0;
            mk_q    <= '0;
            root_q  <= '0;
            lc_q    <= '0;
            lp_q    <= '0;
`ifdef SIGN_WATCHDOG_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            ch_q    <= ch_d;
            cv_q    <= cv_d;
            mk_q    <= mk_d;
            root_q  <= root_d;
            lc_q    <= lc_d;
            lp_q    <= lp_d;
`ifdef SIGN_WATCHDOG_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.sign_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.sign_end   = (state_q == S_DONE);
`ifdef SIGN_WATCHDOG_EN
    assign bus.sign_err   = err_q;
`else
    assign bus.sign_err   = 1'b0;
`endif
    assign bus.tree_start = (state_q == S_TREE);
    assign bus.rnd_start  = (state_q == S_ROUND);
    assign bus.mt_start   = (state_q == S_MERKLE);
    assign bus.hcp_start  = (state_q == S_HCP);
    assign bus.rnd_idx    = idx_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_ch      = ch_q;
    assign bus.wr_cv      = cv_q;
    assign bus.wr_mk      = mk_q;
    assign bus.cv_root    = root_q;
    assign bus.lc         = lc_q;
    assign bus.lp         = lp_q;
endmodule

// File: tb/tb_sign_phase_sequencer.sv
// Directed bench for sign_phase_sequencer: T_ROUNDS=4 and T_ROUNDS=1 instances.
// Watchdog scenario runs only when SIGN_WATCHDOG_EN is defined.
module tb_sign_phase_sequencer;
    localparam int RW = 3;
    localparam int CHW = 16;
    localparam int CVW = 16;
    localparam int MKW = 8;
    localparam int LCW = 12;
    localparam int LPW = 10;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    sign_phase_sequencer_if #(.RIDX_W(RW), .CH_W(CHW), .CV_W(CVW),
        .MK_W(MKW), .LC_W(LCW), .LP_W(LPW)) ifa ();
    sign_phase_sequencer_if #(.RIDX_W(RW), .CH_W(CHW), .CV_W(CVW),
        .MK_W(MKW), .LC_W(LCW), .LP_W(LPW)) ifb ();

    sign_phase_sequencer #(.T_ROUNDS(4), .RIDX_W(RW), .CH_W(CHW),
        .CV_W(CVW), .MK_W(MKW), .LC_W(LCW), .LP_W(LPW),
        .TO_CYCLES(16)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    sign_phase_sequencer #(.T_ROUNDS(1), .RIDX_W(RW), .CH_W(CHW),
        .CV_W(CVW), .MK_W(MKW), .LC_W(LCW), .LP_W(LPW),
        .TO_CYCLES(16)) u_b (.clk(clk), .reset(reset), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write-port monitors
    logic [RW-1:0]  wa_addr[$];
    logic [CHW-1:0] wa_ch[$];
    logic [CVW-1:0] wa_cv[$];
    logic [MKW-1:0] wa_mk[$];
    int   wa_pulses = 0;
    logic wa_prev = 1'b0;
    int   wb_hi = 0;

    always @(posedge clk) begin
        if (ifa.wr_en === 1'b1) begin
            wa_addr.push_back(ifa.wr_addr);
            wa_ch.push_back(ifa.wr_ch);
            wa_cv.push_back(ifa.wr_cv);
            wa_mk.push_back(ifa.wr_mk);
            if (!wa_prev) wa_pulses++;
        end
        wa_prev = (ifa.wr_en === 1'b1);
        if (ifb.wr_en === 1'b1) wb_hi++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic start_sig(input int w);
        case (w)
            0: return ifa.tree_start;
            1: return ifa.rnd_start;
            2: return ifa.mt_start;
            default: return ifa.hcp_start;
        endcase
    endfunction

    task automatic set_done(input int w, input logic v);
        case (w)
            0: ifa.tree_done = v;
            1: ifa.rnd_done = v;
            2: ifa.mt_done = v;
            default: ifa.hcp_done = v;
        endcase
    endtask

    task automatic wait_hi(input int w);
        int n = 0;
        while (start_sig(w) !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk($sformatf("start%0d_seen", w), 32'(start_sig(w)), 32'd1);
    endtask

    // Done arrives on the third edge after start is seen.
    task automatic serve(input int w);
        wait_hi(w);
        tick;
        tick;
        set_done(w, 1'b1);
        tick;
        set_done(w, 1'b0);
        chk($sformatf("start%0d_drop", w), 32'(start_sig(w)), 32'd0);
    endtask

    task automatic clear_mon;
        wa_addr.delete();
        wa_ch.delete();
        wa_cv.delete();
        wa_mk.delete();
        wa_pulses = 0;
    endtask

    task automatic rounds(input int first, input int last);
        for (int t = first; t <= last; t++) begin
            ifa.rnd_ch = CHW'(16'hC000 + t);
            ifa.rnd_cv = CVW'(16'hB000 + t);
            ifa.rnd_mk = MKW'(8'hA0 + t);
            wait_hi(1);
            chk("rnd_idx", 32'(ifa.rnd_idx), 32'(t));
            serve(1);
        end
    endtask

    initial begin
        int hold_bad;
        int n;
        reset = 1'b0;
        ifa.sign_start = 0; ifa.sign_abort = 0;
        ifa.tree_done = 0; ifa.rnd_done = 0;
        ifa.mt_done = 0; ifa.hcp_done = 0;
        ifa.rnd_ch = '0; ifa.rnd_cv = '0; ifa.rnd_mk = '0;
        ifa.mt_root = '0; ifa.hcp_lc = '0; ifa.hcp_lp = '0;
        ifb.sign_start = 0; ifb.sign_abort = 0;
        ifb.tree_done = 0; ifb.rnd_done = 0;
        ifb.mt_done = 0; ifb.hcp_done = 0;
        ifb.rnd_ch = '0; ifb.rnd_cv = '0; ifb.rnd_mk = '0;
        ifb.mt_root = '0; ifb.hcp_lc = '0; ifb.hcp_lp = '0;
        tick;
        tick;
        chk("rst_busy", 32'(ifa.sign_busy), 0);
        chk("rst_end", 32'(ifa.sign_end), 0);
        chk("rst_starts", 32'({ifa.tree_start, ifa.rnd_start,
            ifa.mt_start, ifa.hcp_start, ifa.wr_en}), 0);
        chk("rst_data", 32'({ifa.rnd_idx, ifa.wr_addr, ifa.wr_ch,
            ifa.cv_root}), 0);
        chk("rst_lclp", 32'({ifa.lc, ifa.lp, ifa.wr_mk}), 0);
        reset = 1'b1;
        tick;

        // T1 full run
        clear_mon;
        ifa.sign_start = 1;
        tick;
        chk("t1_tree_start", 32'(ifa.tree_start), 1);
        chk("t1_busy", 32'(ifa.sign_busy), 1);
        serve(0);
        rounds(0, 3);
        ifa.mt_root = 16'h5A5A;
        serve(2);
        ifa.hcp_lc = 12'hABC;
        ifa.hcp_lp = 10'h155;
        serve(3);
        chk("t1_end", 32'(ifa.sign_end), 1);
        chk("t1_err", 32'(ifa.sign_err), 0);
        chk("t1_busy_done", 32'(ifa.sign_busy), 0);
        chk("t1_root", 32'(ifa.cv_root), 32'h5A5A);
        chk("t1_lc", 32'(ifa.lc), 32'hABC);
        chk("t1_lp", 32'(ifa.lp), 32'h155);
        chk("t1_nwr", 32'(wa_addr.size()), 4);
        chk("t1_pulses", 32'(wa_pulses), 4);
        for (int t = 0; t < 4 && t < wa_addr.size(); t++) begin
            chk("t1_wr_addr", 32'(wa_addr[t]), 32'(t));
            chk("t1_wr_ch", 32'(wa_ch[t]), 32'(16'hC000 + t));
            chk("t1_wr_cv", 32'(wa_cv[t]), 32'(16'hB000 + t));
            chk("t1_wr_mk", 32'(wa_mk[t]), 32'(8'hA0 + t));
        end

        // T2 sign_end hold while sign_start stays high
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ifa.sign_end !== 1'b1 || ifa.tree_start !== 1'b0)
                hold_bad++;
        end
        chk("t2_hold", 32'(hold_bad), 0);
        ifa.sign_start = 0;
        tick;
        chk("t2_end_clr", 32'(ifa.sign_end), 0);
        chk("t2_idle", 32'({ifa.sign_busy, ifa.tree_start}), 0);
        ifa.sign_start = 1;
        tick;
        chk("t2_restart", 32'(ifa.tree_start), 1);

        // T4 spurious mt_done during ROUND
        serve(0);
        wait_hi(1);
        ifa.mt_done = 1;
        tick;
        ifa.mt_done = 0;
        chk("t4_rnd_kept", 32'(ifa.rnd_start), 1);
        chk("t4_no_mt", 32'(ifa.mt_start), 0);
        rounds(0, 3);
        wait_hi(2);
        for (int i = 0; i < 5; i++) tick;
        chk("t4_mt_wait", 32'({ifa.mt_start, ifa.hcp_start}), 32'b10);
        ifa.mt_root = 16'h1234;
        serve(2);
        serve(3);
        chk("t4_root", 32'(ifa.cv_root), 32'h1234);
        chk("t4_end", 32'(ifa.sign_end), 1);
        ifa.sign_start = 0;
        tick;

        // T3 abort at round 2
        ifa.sign_start = 1;
        tick;
        serve(0);
        rounds(0, 1);
        wait_hi(1);
        chk("t3_idx2", 32'(ifa.rnd_idx), 2);
        ifa.sign_abort = 1;
        tick;
        ifa.sign_abort = 0;
        ifa.sign_start = 0;
        chk("t3_rnd_start", 32'(ifa.rnd_start), 0);
        chk("t3_wr_en", 32'(ifa.wr_en), 0);
        chk("t3_idx", 32'(ifa.rnd_idx), 0);
        chk("t3_idle", 32'({ifa.sign_busy, ifa.sign_end}), 0);
        chk("t3_root", 32'(ifa.cv_root), 32'h1234);
        tick;

        // T5 single round on u_b
        ifb.sign_start = 1;
        tick;
        chk("t5_tree", 32'(ifb.tree_start), 1);
        ifb.tree_done = 1;
        tick;
        ifb.tree_done = 0;
        chk("t5_rnd", 32'({ifb.rnd_start, ifb.rnd_idx}), 32'b1000);
        ifb.rnd_ch = 16'h7777;
        ifb.rnd_done = 1;
        tick;
        ifb.rnd_done = 0;
        chk("t5_wr", 32'({ifb.wr_en, ifb.wr_addr}), 32'b1000);
        chk("t5_wr_ch", 32'(ifb.wr_ch), 32'h7777);
        tick;
        chk("t5_mt", 32'({ifb.mt_start, ifb.rnd_start, ifb.wr_en}),
            32'b100);
        tick;
        tick;
        chk("t5_nwr", 32'(wb_hi), 1);
        ifb.mt_done = 1;
        tick;
        ifb.mt_done = 0;
        ifb.hcp_done = 1;
        tick;
        ifb.hcp_done = 0;
        chk("t5_end", 32'(ifb.sign_end), 1);
        ifb.sign_start = 0;
        tick;

`ifdef SIGN_WATCHDOG_EN
        // T6 withhold hcp_done
        ifa.hcp_lc = 12'h111;
        ifa.hcp_lp = 10'h222;
        ifa.sign_start = 1;
        tick;
        serve(0);
        rounds(0, 3);
        serve(2);
        wait_hi(3);
        n = 0;
        while (ifa.hcp_start === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        chk("t6_hcp_cycles", 32'(n), 16);
        chk("t6_err", 32'(ifa.sign_err), 1);
        chk("t6_end", 32'(ifa.sign_end), 1);
        chk("t6_lc", 32'(ifa.lc), 32'hABC);
        chk("t6_lp", 32'(ifa.lp), 32'h155);
        ifa.sign_start = 0;
        tick;
        chk("t6_err_clr", 32'({ifa.sign_err, ifa.sign_end}), 0);
`else
        n = 0;
        chk("nowd_err", 32'(ifa.sign_err), 32'(n));
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
